wb_commit_unit: RTL and testbench
=================================

Name: wb_commit_unit

Overview:
- Write-back stage that accepts retiring instructions from MEM, waits for the data-SRAM load response, and aligns and sign-extends load data, including LWL/LWR partial-word merges.
- Drives the GPR write port (we/waddr/wdata/wdata_raw). It is the writer side of the register-file write/bypass interface.
- Holds at most one instruction and raises a stall toward earlier stages while a load response is outstanding.

Parameters:
- DW, 32, datapath width (fixed at 32; byte enables are DW/8 = 4)
- AW, 5, GPR address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEM presents a retiring instruction
- in_ready  out  1  WB can accept this cycle
- in_wen  in  1  instruction writes a GPR
- in_waddr  in  5  destination GPR
- in_result  in  32  ALU/non-load result
- in_load_op  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- in_addr_lo  in  2  effective address bits [1:0]
- flush  in  1  exception/eret flush; kills the held instruction
- data_ok  in  1  data-SRAM read response valid
- data_rdata  in  32  raw word from data SRAM
- we  out  4  per-byte GPR write enable
- waddr  out  5  GPR write address
- wdata  out  32  aligned write data
- wdata_raw  out  32  same aligned value, used by the register-file bypass
- stallreq  out  1  high while a load waits for data_ok

Behaviour:
- Reset: state=IDLE; we=0, waddr=0, wdata=0, wdata_raw=0, stallreq=0, in_ready=1, drop_pending=0.
- States:
  - IDLE: empty.
  - WAIT: load held, response pending.
  - COMMIT: write presented on the outputs for exactly one cycle.
- in_ready = (state != WAIT). An accept happens when in_valid && in_ready && !flush.
- Accept of a non-load (in_load_op=0): next cycle is COMMIT with we = in_wen ? 4'b1111 : 0, wdata = in_result. Latency is 1 cycle.
- Accept of a load with data_ok in the same cycle (and drop_pending=0): align immediately, then COMMIT the next cycle.
- Accept of a load without data_ok: capture the fields and go to WAIT. stallreq = 1 throughout WAIT.
- WAIT with data_ok (drop_pending=0): align, go to COMMIT next cycle, deassert stallreq.
- COMMIT: outputs are valid for one cycle.
  - Another accept in the same cycle leads to COMMIT or WAIT per the rules above.
  - Otherwise go to IDLE with we = 0.
- Alignment, with byte b = data_rdata >> 8*addr_lo:
  - LB sign-extends [7:0]; LBU zero-extends.
  - LH/LHU use the halfword at addr_lo[1] and sign-/zero-extend it.
  - LW uses the word unchanged.
  - For these loads we = 1111.
- LWL, by addr_lo (value, we, wdata bits):
  - 0: we=1000, wdata[31:24]=rd[7:0]
  - 1: we=1100, wdata[31:16]=rd[15:0]
  - 2: we=1110, wdata[31:8]=rd[23:0]
  - 3: we=1111, wdata=rd
- LWR, by addr_lo (value, we, wdata bits):
  - 0: we=1111, wdata=rd
  - 1: we=0111, wdata[23:0]=rd[31:8]
  - 2: we=0011, wdata[15:0]=rd[31:16]
  - 3: we=0001, wdata[7:0]=rd[31:24]
- Bytes not enabled in wdata are 0.
- we is forced to 0 when in_wen=0 or waddr=0.
- wdata_raw == wdata in every cycle.
- Flush:
  - flush in WAIT: go to IDLE with no write. Set drop_pending=1 unless data_ok is high in that same cycle.
  - flush in COMMIT: the write already registered still completes; it is architecturally older.
  - flush with in_valid: no accept.
- drop_pending: the next data_ok is consumed silently and clears the flag. It does not complete a load accepted later.
  - A load accepted while drop_pending=1 always enters WAIT, even if data_ok arrives in that cycle.
- rst in any state, including WAIT, returns all outputs and flags to reset values on the next edge.

Decomposition:
- Shared package:
  - load-op encodings (LOAD_NONE..LOAD_LWR)
  - state encodings (WB_IDLE, WB_WAIT, WB_COMMIT)
  - constant BYTE_EN_ALL = 4'b1111
- One natural sub-module: load_align. It is purely combinational, maps (load_op, addr_lo, rdata) to (be, aligned data), and is reused by the bench reference model.

Test Plan:
- ALU commit: accept in_wen=1, waddr=5, result=0x12345678 -> next cycle we=1111, waddr=5, wdata=wdata_raw=0x12345678; following idle cycle we=0.
- Delayed LB: accept LB, addr_lo=3, no data_ok for 3 cycles, then data_ok with rdata=0x80AABBCC -> stallreq and !in_ready for 3 cycles, then we=1111, wdata=0xFFFFFF80.
- LWL/LWR sweep: rdata=0x11223344, addr_lo=0..3 -> LWL we=1000/1100/1110/1111 with wdata 0x44000000/0x33440000/0x22334400/0x11223344; LWR we=1111/0111/0011/0001 with wdata 0x11223344/0x00112233/0x00001122/0x00000011.
- Flush in WAIT: LW waiting, flush, then accept LHU (rdata 0xBEEF0000 expected), stale data_ok 0xDEADDEAD arrives, then data_ok 0xBEEF0000 with addr_lo=2 -> no write for stale data; then we=1111, wdata=0x0000BEEF.
- $zero suppression: accept LW to waddr=0 with data_ok in the accept cycle -> we=0 in commit cycle; back-to-back ALU accept in the same commit cycle commits the following cycle.
- Reset mid-WAIT: rst while in WAIT with stallreq=1 -> next cycle stallreq=0, in_ready=1, we=0; a later data_ok produces no write.

Source files
------------

// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the write-back commit unit.
// Contents:
//   load_op_e   - load-op encodings presented by MEM on in_load_op
//   wb_state_e  - state encodings of the write-back sequencer
//   BYTE_EN_ALL - full-word byte-enable pattern
package wb_commit_unit_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_LWL  = 3'd6,
    LOAD_LWR  = 3'd7
  } load_op_e;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_WAIT   = 2'd1,
    WB_COMMIT = 2'd2
  } wb_state_e;

  localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

endpackage

// File: rtl/wb_commit_unit_load_align.sv
// load_align: purely combinational load-data aligner.
// Ports:
//   load_op [2:0]  - load kind (load_op_e encoding)
//   addr_lo [1:0]  - effective address bits [1:0]
//   rdata   [31:0] - raw word returned by the data SRAM
//   be      [3:0]  - byte lanes of the destination GPR to update
//   data    [31:0] - aligned / extended data; disabled lanes are zero
module load_align
  import wb_commit_unit_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign sel_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be   = BYTE_EN_ALL;
    data = rdata;
    case (load_op)
      LOAD_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LOAD_LBU: data = {24'h0, sel_byte};
      LOAD_LH:  data = {{16{sel_half[15]}}, sel_half};
      LOAD_LHU: data = {16'h0, sel_half};
      // LWL fills the upper lanes: the low (addr_lo+1) bytes of the word
      // move to the top of the register.
      LOAD_LWL: begin
        data = rdata << {~addr_lo, 3'b000};
        be   = BYTE_EN_ALL << ~addr_lo;
      end
      // LWR fills the lower lanes: the top (4-addr_lo) bytes of the word
      // move to the bottom of the register.
      LOAD_LWR: begin
        data = rdata >> {addr_lo, 3'b000};
        be   = BYTE_EN_ALL >> addr_lo;
      end
      default: begin
        be   = BYTE_EN_ALL;
        data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: write-back stage. Accepts one retiring instruction from
// MEM, waits for the data-SRAM response when it is a load, aligns the load
// data and presents a one-cycle GPR write.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   in_valid / in_ready    - MEM handshake (in_ready low only in WAIT)
//   in_wen, in_waddr       - destination GPR write request
//   in_result              - non-load result
//   in_load_op, in_addr_lo - load kind and address bits [1:0]
//   flush                  - kills the held load and blocks accepts
//   data_ok, data_rdata    - data-SRAM read response
//   we, waddr, wdata       - GPR write port (per-byte enables)
//   wdata_raw              - copy of wdata for the bypass network
//   stallreq               - high while a load waits for its response
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wen,
  input  logic [AW-1:0] in_waddr,
  input  logic [DW-1:0] in_result,
  input  logic [2:0]    in_load_op,
  input  logic [1:0]    in_addr_lo,
  input  logic          flush,
  input  logic          data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic [3:0]    we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic [DW-1:0] wdata_raw,
  output logic          stallreq
);

  wb_state_e     state_q, state_d;
  logic          drop_pending_q, drop_pending_d;
  logic          stallreq_q, stallreq_d;
  logic [3:0]    we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Fields of the load parked in WAIT.
  logic          hold_wen_q, hold_wen_d;
  logic [AW-1:0] hold_waddr_q, hold_waddr_d;
  logic [2:0]    hold_load_op_q, hold_load_op_d;
  logic [1:0]    hold_addr_lo_q, hold_addr_lo_d;

  logic          accept;
  logic          use_hold;
  logic [2:0]    al_op;
  logic [1:0]    al_addr;
  logic [3:0]    al_be;
  logic [DW-1:0] al_data;
  logic          in_gpr_wr;
  logic          hold_gpr_wr;

  assign in_ready = (state_q != WB_WAIT);
  assign accept   = in_valid && in_ready && !flush;

  // One aligner serves both the same-cycle path and the WAIT path; the
  // source of op/addr is chosen by the state.
  assign use_hold = (state_q == WB_WAIT);
  assign al_op    = use_hold ? hold_load_op_q : in_load_op;
  assign al_addr  = use_hold ? hold_addr_lo_q : in_addr_lo;

  // Writes to $zero or without wen never reach the register file.
  assign in_gpr_wr   = in_wen && (in_waddr != '0);
  assign hold_gpr_wr = hold_wen_q && (hold_waddr_q != '0);

  load_align u_load_align (
    .load_op (al_op),
    .addr_lo (al_addr),
    .rdata   (data_rdata),
    .be      (al_be),
    .data    (al_data)
  );

  always_comb begin
    state_d        = WB_IDLE;
    drop_pending_d = drop_pending_q;
    stallreq_d     = 1'b0;
    we_d           = '0;
    waddr_d        = '0;
    wdata_d        = '0;
    hold_wen_d     = hold_wen_q;
    hold_waddr_d   = hold_waddr_q;
    hold_load_op_d = hold_load_op_q;
    hold_addr_lo_d = hold_addr_lo_q;

    if (state_q == WB_WAIT) begin
      if (flush) begin
        // A response still in flight for the killed load must be swallowed.
        state_d        = WB_IDLE;
        drop_pending_d = drop_pending_q || !data_ok;
      end else if (data_ok && drop_pending_q) begin
        // Stale response from a flushed load; keep waiting for ours.
        drop_pending_d = 1'b0;
        state_d        = WB_WAIT;
        stallreq_d     = 1'b1;
      end else if (data_ok) begin
        state_d = WB_COMMIT;
        we_d    = hold_gpr_wr ? al_be : 4'b0000;
        waddr_d = hold_waddr_q;
        wdata_d = al_data;
      end else begin
        state_d    = WB_WAIT;
        stallreq_d = 1'b1;
      end
    end else begin
      if (data_ok && drop_pending_q) begin
        drop_pending_d = 1'b0;
      end
      if (accept) begin
        if (in_load_op == LOAD_NONE) begin
          state_d = WB_COMMIT;
          we_d    = in_gpr_wr ? BYTE_EN_ALL : 4'b0000;
          waddr_d = in_waddr;
          wdata_d = in_result;
        end else if (data_ok && !drop_pending_q) begin
          state_d = WB_COMMIT;
          we_d    = in_gpr_wr ? al_be : 4'b0000;
          waddr_d = in_waddr;
          wdata_d = al_data;
        end else begin
          // A data_ok seen while drop_pending belongs to the flushed load.
          state_d        = WB_WAIT;
          stallreq_d     = 1'b1;
          hold_wen_d     = in_wen;
          hold_waddr_d   = in_waddr;
          hold_load_op_d = in_load_op;
          hold_addr_lo_d = in_addr_lo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WB_IDLE;
      drop_pending_q <= 1'b0;
      stallreq_q     <= 1'b0;
      we_q           <= '0;
      waddr_q        <= '0;
      wdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      drop_pending_q <= drop_pending_d;
      stallreq_q     <= stallreq_d;
      we_q           <= we_d;
      waddr_q        <= waddr_d;
      wdata_q        <= wdata_d;
    end
  end

  // Held load fields only matter while in WAIT, which reset leaves.
  always_ff @(posedge clk) begin
    hold_wen_q     <= hold_wen_d;
    hold_waddr_q   <= hold_waddr_d;
    hold_load_op_q <= hold_load_op_d;
    hold_addr_lo_q <= hold_addr_lo_d;
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wdata_raw = wdata_q;
  assign stallreq  = stallreq_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed testbench for wb_commit_unit with hand-computed expectations.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_wen = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] in_result = '0;
  logic [2:0]  in_load_op = '0;
  logic [1:0]  in_addr_lo = '0;
  logic        flush = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic [3:0]  we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] wdata_raw;
  logic        stallreq;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_commit_unit #(.DW(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wen     (in_wen),
    .in_waddr   (in_waddr),
    .in_result  (in_result),
    .in_load_op (in_load_op),
    .in_addr_lo (in_addr_lo),
    .flush      (flush),
    .data_ok    (data_ok),
    .data_rdata (data_rdata),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .wdata_raw  (wdata_raw),
    .stallreq   (stallreq)
  );

  // Full observable output vector: we, waddr, wdata, wdata_raw, stallreq, in_ready.
  function automatic logic [74:0] obs_all();
    return {we, waddr, wdata, wdata_raw, stallreq, in_ready};
  endfunction

  // Control subset: we, stallreq, in_ready.
  function automatic logic [5:0] obs_ctl();
    return {we, stallreq, in_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid   = 1'b0;
    in_wen     = 1'b0;
    in_waddr   = '0;
    in_result  = '0;
    in_load_op = '0;
    in_addr_lo = '0;
    flush      = 1'b0;
    data_ok    = 1'b0;
    data_rdata = '0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] a, input logic wen,
                       input logic [4:0] wa, input logic [31:0] res);
    in_valid   = 1'b1;
    in_load_op = op;
    in_addr_lo = a;
    in_wen     = wen;
    in_waddr   = wa;
    in_result  = res;
  endtask

  task automatic test_reset();
    logic [74:0] e;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    e = {4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL reset_state: got %h want %h", obs_all(), e);
    else n_pass++;
  endtask

  task automatic test_alu_commit();
    logic [74:0] e;
    logic [5:0]  c;
    drive(3'd0, 2'd0, 1'b1, 5'd5, 32'h12345678);
    tick();
    clear_inputs();
    e = {4'hF, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL alu_commit: got %h want %h", obs_all(), e);
    else n_pass++;
    tick();
    c = {4'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL alu_idle_after: got %h want %h", obs_ctl(), c);
    else n_pass++;
  endtask

  task automatic test_delayed_lb();
    logic [74:0] e;
    logic [5:0]  c;
    drive(3'd1, 2'd3, 1'b1, 5'd7, 32'h0);
    c = {4'h0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      tick();
      in_valid = 1'b0;
      n_total++;
      if (obs_ctl() !== c) $display("FAIL lb_wait_stall%0d: got %h want %h", i, obs_ctl(), c);
      else n_pass++;
    end
    data_ok    = 1'b1;
    data_rdata = 32'h80AABBCC;
    tick();
    clear_inputs();
    e = {4'hF, 5'd7, 32'hFFFFFF80, 32'hFFFFFF80, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL lb_commit: got %h want %h", obs_all(), e);
    else n_pass++;
    tick();
  endtask

  task automatic test_lwl_lwr();
    logic [3:0]  lwl_be [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    logic [31:0] lwl_d  [4] = '{32'h44000000, 32'h33440000, 32'h22334400, 32'h11223344};
    logic [3:0]  lwr_be [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [31:0] lwr_d  [4] = '{32'h11223344, 32'h00112233, 32'h00001122, 32'h00000011};
    logic [74:0] e;
    data_ok    = 1'b1;
    data_rdata = 32'h11223344;
    for (int k = 0; k < 4; k++) begin
      drive(3'd6, 2'(k), 1'b1, 5'd10, 32'h0);
      tick();
      e = {lwl_be[k], 5'd10, lwl_d[k], lwl_d[k], 1'b0, 1'b1};
      n_total++;
      if (obs_all() !== e) $display("FAIL lwl_a%0d: got %h want %h", k, obs_all(), e);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      drive(3'd7, 2'(k), 1'b1, 5'd12, 32'h0);
      tick();
      e = {lwr_be[k], 5'd12, lwr_d[k], lwr_d[k], 1'b0, 1'b1};
      n_total++;
      if (obs_all() !== e) $display("FAIL lwr_a%0d: got %h want %h", k, obs_all(), e);
      else n_pass++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush_wait();
    logic [74:0] e;
    logic [5:0]  c;
    // LW parked, then flushed with no response outstanding in that cycle.
    drive(3'd5, 2'd0, 1'b1, 5'd3, 32'h0);
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    c = {4'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL flush_to_idle: got %h want %h", obs_ctl(), c);
    else n_pass++;
    // in_valid together with flush must not be accepted.
    drive(3'd0, 2'd0, 1'b1, 5'd8, 32'h55555555);
    tick();
    flush = 1'b0;
    n_total++;
    if (obs_ctl() !== c) $display("FAIL flush_blocks_accept: got %h want %h", obs_ctl(), c);
    else n_pass++;
    drive(3'd4, 2'd2, 1'b1, 5'd9, 32'h0);
    tick();
    in_valid = 1'b0;
    c = {4'h0, 1'b1, 1'b0};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL lhu_wait: got %h want %h", obs_ctl(), c);
    else n_pass++;
    // Stale response for the flushed LW.
    data_ok    = 1'b1;
    data_rdata = 32'hDEADDEAD;
    tick();
    n_total++;
    if (obs_ctl() !== c) $display("FAIL stale_dropped: got %h want %h", obs_ctl(), c);
    else n_pass++;
    data_rdata = 32'hBEEF0000;
    tick();
    clear_inputs();
    e = {4'hF, 5'd9, 32'h0000BEEF, 32'h0000BEEF, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL lhu_commit: got %h want %h", obs_all(), e);
    else n_pass++;
    tick();
    // Load accepted while a drop is pending ignores the same-cycle data_ok.
    drive(3'd5, 2'd0, 1'b1, 5'd3, 32'h0);
    tick();
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(3'd1, 2'd0, 1'b1, 5'd11, 32'h0);
    data_ok    = 1'b1;
    data_rdata = 32'hDEADDEAD;
    tick();
    in_valid   = 1'b0;
    data_rdata = 32'h000000FE;
    c = {4'h0, 1'b1, 1'b0};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL drop_accept_waits: got %h want %h", obs_ctl(), c);
    else n_pass++;
    tick();
    clear_inputs();
    e = {4'hF, 5'd11, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL drop_then_lb_commit: got %h want %h", obs_all(), e);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back_zero();
    logic [74:0] e;
    logic [5:0]  c;
    drive(3'd5, 2'd0, 1'b1, 5'd0, 32'h0);
    data_ok    = 1'b1;
    data_rdata = 32'hCAFEF00D;
    tick();
    data_ok = 1'b0;
    c = {4'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL zero_reg_suppressed: got %h want %h", obs_ctl(), c);
    else n_pass++;
    drive(3'd0, 2'd0, 1'b1, 5'd4, 32'hA5A5A5A5);
    tick();
    e = {4'hF, 5'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL back_to_back_alu: got %h want %h", obs_all(), e);
    else n_pass++;
    drive(3'd0, 2'd0, 1'b0, 5'd6, 32'h00000001);
    tick();
    clear_inputs();
    n_total++;
    if (obs_ctl() !== c) $display("FAIL wen0_suppressed: got %h want %h", obs_ctl(), c);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic [74:0] e;
    logic [5:0]  c;
    drive(3'd5, 2'd0, 1'b1, 5'd2, 32'h0);
    tick();
    clear_inputs();
    c = {4'h0, 1'b1, 1'b0};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL rst_pre_wait: got %h want %h", obs_ctl(), c);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = {4'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_all() !== e) $display("FAIL rst_mid_wait: got %h want %h", obs_all(), e);
    else n_pass++;
    data_ok    = 1'b1;
    data_rdata = 32'h12345678;
    tick();
    clear_inputs();
    c = {4'h0, 1'b0, 1'b1};
    n_total++;
    if (obs_ctl() !== c) $display("FAIL rst_late_data_ok: got %h want %h", obs_ctl(), c);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_commit();
    test_delayed_lb();
    test_lwl_lwr();
    test_flush_wait();
    test_back_to_back_zero();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
